// File: rtl/dram_arb_pkg.sv
// Shared encodings for the two-port data-RAM arbiter.
// State codes, byte-enable shorthands and arbitration modes.
package dram_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t RMW_RD = 2'd1;
    localparam state_t ACC    = 2'd2;
    localparam state_t DONE   = 2'd3;

    localparam logic [3:0] BE_FULL = 4'hF;
    localparam logic [3:0] BE_NONE = 4'h0;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

endpackage

// File: rtl/dram_arb_if.sv
// Request/ack bundle of one arbiter port.
// master = CPU or loader side, slave = arbiter side.
interface dram_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [3:0]        be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/dram_arbiter_rr_arb2.sv
// Two-requester grant logic with per-port masking.
// Round-robin against last_gnt, or fixed priority for port 0.
module rr_arb2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_mask0,
    input  logic i_mask1,
    input  logic i_last_gnt,
    input  logic i_mode,
    output logic o_gnt,
    output logic o_gnt_id
);
    logic w_e0;
    logic w_e1;

    assign w_e0  = i_req0 & ~i_mask0;
    assign w_e1  = i_req1 & ~i_mask1;
    assign o_gnt = w_e0 | w_e1;

    always_comb begin
        o_gnt_id = 1'b0;
        unique case ({w_e1, w_e0})
            2'b11:   o_gnt_id = i_mode ? 1'b0 : ~i_last_gnt;
            2'b10:   o_gnt_id = 1'b1;
            default: o_gnt_id = 1'b0;
        endcase
    end
endmodule

// File: rtl/dram_arbiter.sv
// Two-port sequencer in front of the word data RAM.
// Sub-word stores become a read-modify-write pair.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int ARB_MODE = ARB_RR,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    dram_arb_if.slave         p0,
    dram_arb_if.slave         p1,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);
    state_t              r_state;
    logic                r_gnt_id;
    logic                r_last_gnt;
    logic                r_we;
    logic                r_partial;
    logic [3:0]          r_be;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_merge;
    logic                r_ack0;
    logic                r_ack1;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;

    logic                w_gnt;
    logic                w_gnt_id;
    logic                w_we;
    logic [3:0]          w_be;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_merge;

    // A port is masked while its ack is showing, so a held req is not reissued
    rr_arb2 u_arb (
        .i_req0     (p0.req),
        .i_req1     (p1.req),
        .i_mask0    (r_ack0),
        .i_mask1    (r_ack1),
        .i_last_gnt (r_last_gnt),
        .i_mode     (ARB_MODE == ARB_FIXED),
        .o_gnt      (w_gnt),
        .o_gnt_id   (w_gnt_id)
    );

    assign w_we    = w_gnt_id ? p1.we    : p0.we;
    assign w_be    = w_gnt_id ? p1.be    : p0.be;
    assign w_addr  = w_gnt_id ? p1.addr  : p0.addr;
    assign w_wdata = w_gnt_id ? p1.wdata : p0.wdata;

    always_comb begin
        w_merge = ram_rdata;
        for (int i = 0; i < 4; i++) begin
            if (r_be[i]) w_merge[8*i +: 8] = r_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_gnt_id   <= 1'b0;
            r_last_gnt <= 1'b1;
            r_we       <= 1'b0;
            r_partial  <= 1'b0;
            r_be       <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_merge    <= '0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_gnt) begin
                        r_gnt_id   <= w_gnt_id;
                        r_last_gnt <= w_gnt_id;
                        r_we       <= w_we;
                        r_be       <= w_be;
                        r_addr     <= w_addr;
                        r_wdata    <= w_wdata;
                        r_partial  <= w_we && (w_be != BE_FULL)
                                      && (w_be != BE_NONE);
                        if (!w_we || w_be == BE_FULL)
                            r_state <= ACC;
                        else if (w_be == BE_NONE)
                            r_state <= DONE;
                        else
                            r_state <= RMW_RD;
                    end
                end
                RMW_RD: begin
                    r_merge <= w_merge;
                    r_state <= ACC;
                end
                ACC: begin
                    if (!r_we) begin
                        if (r_gnt_id) r_rdata1 <= ram_rdata;
                        else          r_rdata0 <= ram_rdata;
                    end
                    r_state <= DONE;
                end
                DONE: begin
                    r_ack0  <= ~r_gnt_id;
                    r_ack1  <= r_gnt_id;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ram_ce    = (r_state == RMW_RD) || (r_state == ACC);
    assign ram_we    = (r_state == ACC) && r_we;
    assign ram_addr  = ram_ce ? r_addr : '0;
    assign ram_wdata = ram_we ? (r_partial ? r_merge : r_wdata) : '0;
    assign busy      = (r_state != IDLE);

    assign p0.ack   = r_ack0;
    assign p0.rdata = r_rdata0;
    assign p1.ack   = r_ack1;
    assign p1.rdata = r_rdata1;
endmodule

// File: tb/tb_dram_arbiter.sv
// Scoreboard bench: instance A round-robin, instance B fixed priority.
// Port index k = inst*2 + port; each k has its own expected-ack queue.
module tb_dram_arbiter;
    import dram_arb_pkg::*;

    typedef struct {
        int          cyc;
        bit          chk;
        logic [31:0] rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req_v   [4];
    logic        we_v    [4];
    logic [3:0]  be_v    [4];
    logic [31:0] addr_v  [4];
    logic [31:0] wdata_v [4];
    logic        ack_v   [4];
    logic [31:0] rdata_v [4];
    exp_t        q [4][$];

    dram_arb_if ifs [4] ();

    for (genvar g = 0; g < 4; g++) begin : g_if
        assign ifs[g].req   = req_v[g];
        assign ifs[g].we    = we_v[g];
        assign ifs[g].be    = be_v[g];
        assign ifs[g].addr  = addr_v[g];
        assign ifs[g].wdata = wdata_v[g];
        assign ack_v[g]     = ifs[g].ack;
        assign rdata_v[g]   = ifs[g].rdata;
    end

    logic        a_ce, a_we, a_busy, b_ce, b_we, b_busy;
    logic [31:0] a_addr, a_wd, a_rd, b_addr, b_wd, b_rd;
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    int          a_wcnt = 0;
    int          a_ccnt = 0;

    assign a_rd = mem_a[a_addr[9:2]];
    assign b_rd = mem_b[b_addr[9:2]];

    always_ff @(posedge clk) begin
        if (a_ce && a_we) mem_a[a_addr[9:2]] <= a_wd;
        if (b_ce && b_we) mem_b[b_addr[9:2]] <= b_wd;
        if (a_ce && a_we) a_wcnt <= a_wcnt + 1;
        if (a_ce) a_ccnt <= a_ccnt + 1;
    end

    dram_arbiter #(.ARB_MODE(ARB_RR)) u_a (
        .clk(clk), .rst_n(rst_n),
        .p0(ifs[0]), .p1(ifs[1]),
        .ram_ce(a_ce), .ram_we(a_we),
        .ram_addr(a_addr), .ram_wdata(a_wd),
        .ram_rdata(a_rd), .busy(a_busy)
    );

    dram_arbiter #(.ARB_MODE(ARB_FIXED)) u_b (
        .clk(clk), .rst_n(rst_n),
        .p0(ifs[2]), .p1(ifs[3]),
        .ram_ce(b_ce), .ram_we(b_we),
        .ram_addr(b_addr), .ram_wdata(b_wd),
        .ram_rdata(b_rd), .busy(b_busy)
    );

    function automatic void chk32(string nm, logic [31:0] act,
                                  logic [31:0] ex);
        checks++;
        if (act !== ex) begin
            failures++;
            $display("FAIL %s actual=%h required=%h cyc=%0d",
                     nm, act, ex, cyc);
        end
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            if (ack_v[k] === 1'b1) begin
                if (q[k].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL ack_unexpected port=%0d actual=1 required=0 cyc=%0d",
                             k, cyc);
                end else begin
                    e = q[k].pop_front();
                    chk32($sformatf("ack_cycle_p%0d", k), cyc, e.cyc);
                    if (e.chk)
                        chk32($sformatf("rdata_p%0d", k), rdata_v[k], e.rd);
                end
            end
        end
    end

    function automatic logic busy_of(int k);
        return (k < 2) ? a_busy : b_busy;
    endfunction

    // Holds req with stable fields until n acks have been seen
    task automatic acc(input int k, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int n, input int first, input int period,
                       input bit chk, input logic [31:0] ex,
                       input bit chk_idle);
        exp_t e;
        int   got;
        @(posedge clk);
        #1;
        we_v[k]    = we;
        be_v[k]    = be;
        addr_v[k]  = addr;
        wdata_v[k] = wdata;
        req_v[k]   = 1'b1;
        for (int i = 0; i < n; i++) begin
            e.cyc = cyc + first + i * period;
            e.chk = chk;
            e.rd  = ex;
            q[k].push_back(e);
        end
        got = 0;
        for (int t = 0; t < 200 && got < n; t++) begin
            @(negedge clk);
            if (ack_v[k] === 1'b1) begin
                got++;
                if (got == n && chk_idle)
                    chk32("busy_in_ack_cycle", 32'(busy_of(k)), 32'd0);
            end
        end
        if (got < n) chk32($sformatf("ack_timeout_p%0d", k), got, n);
        @(posedge clk);
        #1;
        req_v[k] = 1'b0;
        if (chk_idle) begin
            @(negedge clk);
            chk32("no_regrant_busy", 32'(busy_of(k)), 32'd0);
        end
    endtask

    int w0, c0;

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req_v[k]   = 1'b0;
            we_v[k]    = 1'b0;
            be_v[k]    = 4'h0;
            addr_v[k]  = '0;
            wdata_v[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk32("rst_busy", 32'(a_busy), 32'd0);
        chk32("rst_ce", 32'(a_ce), 32'd0);
        chk32("rst_we", 32'(a_we), 32'd0);
        chk32("rst_addr", a_addr, 32'd0);
        chk32("rst_wdata", a_wd, 32'd0);
        chk32("rst_ack", {30'd0, ack_v[1], ack_v[0]}, 32'd0);
        chk32("rst_rdata0", rdata_v[0], 32'd0);
        chk32("rst_rdata1", rdata_v[1], 32'd0);
        rst_n = 1'b1;

        w0 = a_wcnt;
        acc(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1, 3, 1, 1'b0, '0, 1'b0);
        chk32("full_write_cycles", a_wcnt - w0, 32'd1);
        w0 = a_wcnt;
        acc(0, 1'b0, 4'hF, 32'h10, 32'h0, 1, 3, 1, 1'b1, 32'hDEADBEEF, 1'b1);
        chk32("read_no_write", a_wcnt - w0, 32'd0);

        acc(0, 1'b1, 4'hF, 32'h30, 32'h55555555, 1, 3, 1, 1'b0, '0, 1'b0);
        c0 = a_ccnt;
        acc(0, 1'b1, 4'h0, 32'h30, 32'hFFFFFFFF, 1, 2, 1, 1'b0, '0, 1'b0);
        chk32("be0_no_ce", a_ccnt - c0, 32'd0);
        chk32("be0_mem", mem_a[8'h0C], 32'h55555555);
        chk32("rdata0_held", rdata_v[0], 32'hDEADBEEF);

        acc(1, 1'b1, 4'hF, 32'h20, 32'h11223344, 1, 3, 1, 1'b0, '0, 1'b0);
        c0 = a_ccnt;
        w0 = a_wcnt;
        acc(1, 1'b1, 4'b0010, 32'h20, 32'h0000AA00, 1, 4, 1, 1'b0, '0, 1'b0);
        chk32("rmw_ce_cycles", a_ccnt - c0, 32'd2);
        chk32("rmw_write_cycles", a_wcnt - w0, 32'd1);
        chk32("rmw_mem", mem_a[8'h08], 32'h1122AA44);
        acc(1, 1'b0, 4'hF, 32'h20, 32'h0, 1, 3, 1, 1'b1, 32'h1122AA44, 1'b0);

        // last grant was port 1, so port 0 leads the alternation
        fork
            acc(0, 1'b0, 4'hF, 32'h10, 32'h0, 3, 3, 6, 1'b1, 32'hDEADBEEF, 1'b0);
            acc(1, 1'b0, 4'hF, 32'h20, 32'h0, 3, 6, 6, 1'b1, 32'h1122AA44, 1'b0);
        join

        acc(3, 1'b1, 4'hF, 32'h20, 32'h600DCAFE, 1, 3, 1, 1'b0, '0, 1'b0);
        acc(2, 1'b1, 4'hF, 32'h10, 32'h0BADF00D, 1, 3, 1, 1'b0, '0, 1'b0);
        // port 0 was granted last, yet fixed priority still picks it
        fork
            acc(2, 1'b0, 4'hF, 32'h10, 32'h0, 2, 3, 6, 1'b1, 32'h0BADF00D, 1'b0);
            acc(3, 1'b0, 4'hF, 32'h20, 32'h0, 2, 6, 6, 1'b1, 32'h600DCAFE, 1'b0);
        join

        acc(0, 1'b1, 4'hF, 32'h40, 32'hCAFEF00D, 1, 3, 1, 1'b0, '0, 1'b0);
        @(posedge clk);
        #1;
        we_v[0]    = 1'b1;
        be_v[0]    = 4'b0001;
        addr_v[0]  = 32'h40;
        wdata_v[0] = 32'h000000AA;
        req_v[0]   = 1'b1;
        @(posedge clk);
        #1;
        chk32("rmw_rd_ce", {30'd0, a_ce, a_we}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk32("midrst_busy", 32'(a_busy), 32'd0);
        chk32("midrst_ce", 32'(a_ce), 32'd0);
        chk32("midrst_addr", a_addr, 32'd0);
        chk32("midrst_rdata0", rdata_v[0], 32'd0);
        req_v[0] = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        chk32("midrst_mem", mem_a[8'h10], 32'hCAFEF00D);
        acc(0, 1'b0, 4'hF, 32'h40, 32'h0, 1, 3, 1, 1'b1, 32'hCAFEF00D, 1'b0);

        repeat (4) @(posedge clk);
        for (int k = 0; k < 4; k++)
            chk32($sformatf("pending_acks_p%0d", k), q[k].size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
